// File: rtl/tlb_pkg.sv
// Shared constants, request/result records and ELO packing for the TLB maintenance sequencer.
package tlb_pkg;

    localparam int unsigned TLBNUM = 16;
    localparam int unsigned IW     = $clog2(TLBNUM);

    localparam logic [2:0] TLBOP_SRCH = 3'd0;
    localparam logic [2:0] TLBOP_RD   = 3'd1;
    localparam logic [2:0] TLBOP_WR   = 3'd2;
    localparam logic [2:0] TLBOP_FILL = 3'd3;
    localparam logic [2:0] TLBOP_INV  = 3'd4;

    localparam logic [5:0] ECODE_TLBR  = 6'h3F;
    localparam logic [4:0] INV_OP_MAX  = 5'd6;

    localparam int unsigned ELO_V       = 0;
    localparam int unsigned ELO_D       = 1;
    localparam int unsigned ELO_PLV     = 2;
    localparam int unsigned ELO_MAT     = 4;
    localparam int unsigned ELO_G       = 6;
    localparam int unsigned ELO_PPN_LSB = 8;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd21;

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    typedef struct packed {
        logic [2:0]    op;
        logic [4:0]    inv_op;
        logic [9:0]    inv_asid;
        logic [19:0]   inv_va_hi;
        logic [IW-1:0] idx;
        logic [5:0]    ps;
        logic          ne;
        logic [18:0]   vppn;
        logic [31:0]   elo0;
        logic [31:0]   elo1;
        logic [9:0]    asid;
        logic [5:0]    ecode;
        logic [IW-1:0] fill_idx;
    } req_t;

    typedef struct packed {
        logic [2:0]    op;
        logic          ine;
        logic [IW-1:0] index;
        logic          ne;
        logic [5:0]    ps;
        logic [18:0]   vppn;
        logic [9:0]    asid;
        logic [31:0]   elo0;
        logic [31:0]   elo1;
    } wb_t;

    function automatic logic [31:0] pack_elo(input logic [19:0] ppn, input logic g,
                                             input logic [1:0] mat, input logic [1:0] plv,
                                             input logic d, input logic v);
        logic [31:0] elo;
        elo                     = '0;
        elo[ELO_PPN_LSB +: 20]  = ppn;
        elo[ELO_G]              = g;
        elo[ELO_MAT +: 2]       = mat;
        elo[ELO_PLV +: 2]       = plv;
        elo[ELO_D]              = d;
        elo[ELO_V]              = v;
        return elo;
    endfunction

endpackage

// File: rtl/tlb_fill_ctr.sv
// Free-running wrapping index counter used to pick the TLBFILL victim entry.
module tlb_fill_ctr
    import tlb_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] idx_d, idx_q;

    always_comb idx_d = idx_q + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/tlb_ctrl.sv
// TLB maintenance sequencer: captures a request, drives the TLB ports for one cycle,
// then reports the CSR update for one cycle.
module tlb_ctrl
    import tlb_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    req_inv_op,
    input  logic [9:0]    req_inv_asid,
    input  logic [31:0]   req_inv_va,
    input  logic [IW-1:0] csr_tlbidx_index,
    input  logic [5:0]    csr_tlbidx_ps,
    input  logic          csr_tlbidx_ne,
    input  logic [18:0]   csr_tlbehi_vppn,
    input  logic [31:0]   csr_tlbelo0,
    input  logic [31:0]   csr_tlbelo1,
    input  logic [9:0]    csr_asid,
    input  logic [5:0]    csr_estat_ecode,
    output logic          tlb_s1_sel,
    output logic [18:0]   tlb_s1_vppn,
    output logic          tlb_s1_va_bit12,
    output logic [9:0]    tlb_s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic [IW-1:0] tlb_r_index,
    input  logic          r_e,
    input  logic [18:0]   r_vppn,
    input  logic [5:0]    r_ps,
    input  logic [9:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_ppn0,
    input  logic [1:0]    r_plv0,
    input  logic [1:0]    r_mat0,
    input  logic          r_d0,
    input  logic          r_v0,
    input  logic [19:0]   r_ppn1,
    input  logic [1:0]    r_plv1,
    input  logic [1:0]    r_mat1,
    input  logic          r_d1,
    input  logic          r_v1,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic          tlb_w_e,
    output logic [18:0]   tlb_w_vppn,
    output logic [5:0]    tlb_w_ps,
    output logic [9:0]    tlb_w_asid,
    output logic          tlb_w_g,
    output logic [19:0]   tlb_w_ppn0,
    output logic [1:0]    tlb_w_plv0,
    output logic [1:0]    tlb_w_mat0,
    output logic          tlb_w_d0,
    output logic          tlb_w_v0,
    output logic [19:0]   tlb_w_ppn1,
    output logic [1:0]    tlb_w_plv1,
    output logic [1:0]    tlb_w_mat1,
    output logic          tlb_w_d1,
    output logic          tlb_w_v1,
    output logic          tlb_invtlb_valid,
    output logic [4:0]    tlb_invtlb_op,
    output logic          wb_valid,
    output logic [2:0]    wb_op,
    output logic          wb_ine,
    output logic [IW-1:0] wb_index,
    output logic          wb_ne,
    output logic [5:0]    wb_ps,
    output logic [18:0]   wb_vppn,
    output logic [9:0]    wb_asid,
    output logic [31:0]   wb_elo0,
    output logic [31:0]   wb_elo1
);

    state_e        state_d, state_q;
    req_t          req_d, req_q;
    wb_t           wb_d, wb_q;
    logic [IW-1:0] fill_idx;
    logic          issue;

    tlb_fill_ctr u_fill_ctr (
        .clk    (clk),
        .resetn (resetn),
        .idx_o  (fill_idx)
    );

    assign issue     = (state_q == StIssue);
    assign req_ready = (state_q == StIdle);
    assign wb_valid  = (state_q == StResp);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d         = StIssue;
                    req_d.op        = req_op;
                    req_d.inv_op    = req_inv_op;
                    req_d.inv_asid  = req_inv_asid;
                    req_d.inv_va_hi = req_inv_va[31:12];
                    req_d.idx       = csr_tlbidx_index;
                    req_d.ps        = csr_tlbidx_ps;
                    req_d.ne        = csr_tlbidx_ne;
                    req_d.vppn      = csr_tlbehi_vppn;
                    req_d.elo0      = csr_tlbelo0;
                    req_d.elo1      = csr_tlbelo1;
                    req_d.asid      = csr_asid;
                    req_d.ecode     = csr_estat_ecode;
                    req_d.fill_idx  = (req_op == TLBOP_FILL) ? fill_idx : req_q.fill_idx;
                end
            end
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // TLB ports are driven only from latched request state, and only during ISSUE.
    always_comb begin
        tlb_s1_sel       = 1'b0;
        tlb_s1_vppn      = '0;
        tlb_s1_va_bit12  = 1'b0;
        tlb_s1_asid      = '0;
        tlb_r_index      = '0;
        tlb_we           = 1'b0;
        tlb_w_index      = '0;
        tlb_w_e          = 1'b0;
        tlb_w_vppn       = '0;
        tlb_w_ps         = '0;
        tlb_w_asid       = '0;
        tlb_w_g          = 1'b0;
        tlb_w_ppn0       = '0;
        tlb_w_plv0       = '0;
        tlb_w_mat0       = '0;
        tlb_w_d0         = 1'b0;
        tlb_w_v0         = 1'b0;
        tlb_w_ppn1       = '0;
        tlb_w_plv1       = '0;
        tlb_w_mat1       = '0;
        tlb_w_d1         = 1'b0;
        tlb_w_v1         = 1'b0;
        tlb_invtlb_valid = 1'b0;
        tlb_invtlb_op    = '0;
        if (issue) begin
            case (req_q.op)
                TLBOP_SRCH: begin
                    tlb_s1_sel  = 1'b1;
                    tlb_s1_vppn = req_q.vppn;
                    tlb_s1_asid = req_q.asid;
                end
                TLBOP_RD: tlb_r_index = req_q.idx;
                TLBOP_WR, TLBOP_FILL: begin
                    tlb_we      = 1'b1;
                    tlb_w_index = (req_q.op == TLBOP_FILL) ? req_q.fill_idx : req_q.idx;
                    // A refill handler always creates a valid entry regardless of NE.
                    tlb_w_e     = (req_q.ecode == ECODE_TLBR) ? 1'b1 : ~req_q.ne;
                    tlb_w_vppn  = req_q.vppn;
                    tlb_w_ps    = req_q.ps;
                    tlb_w_asid  = req_q.asid;
                    tlb_w_g     = req_q.elo0[ELO_G] & req_q.elo1[ELO_G];
                    tlb_w_ppn0  = req_q.elo0[ELO_PPN_LSB +: 20];
                    tlb_w_plv0  = req_q.elo0[ELO_PLV +: 2];
                    tlb_w_mat0  = req_q.elo0[ELO_MAT +: 2];
                    tlb_w_d0    = req_q.elo0[ELO_D];
                    tlb_w_v0    = req_q.elo0[ELO_V];
                    tlb_w_ppn1  = req_q.elo1[ELO_PPN_LSB +: 20];
                    tlb_w_plv1  = req_q.elo1[ELO_PLV +: 2];
                    tlb_w_mat1  = req_q.elo1[ELO_MAT +: 2];
                    tlb_w_d1    = req_q.elo1[ELO_D];
                    tlb_w_v1    = req_q.elo1[ELO_V];
                end
                TLBOP_INV: begin
                    if (req_q.inv_op <= INV_OP_MAX) begin
                        tlb_invtlb_valid = 1'b1;
                        tlb_invtlb_op    = req_q.inv_op;
                        tlb_s1_sel       = 1'b1;
                        tlb_s1_vppn      = req_q.inv_va_hi[19:1];
                        tlb_s1_va_bit12  = req_q.inv_va_hi[0];
                        tlb_s1_asid      = req_q.inv_asid;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wb_d = wb_q;
        if (issue) begin
            wb_d    = '0;
            wb_d.op = req_q.op;
            case (req_q.op)
                TLBOP_SRCH: begin
                    wb_d.index = s1_found ? s1_index : req_q.idx;
                    wb_d.ne    = ~s1_found;
                end
                TLBOP_RD: begin
                    wb_d.index = req_q.idx;
                    if (r_e) begin
                        wb_d.ps   = r_ps;
                        wb_d.vppn = r_vppn;
                        wb_d.asid = r_asid;
                        wb_d.elo0 = pack_elo(r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0);
                        wb_d.elo1 = pack_elo(r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1);
                    end else begin
                        wb_d.ne = 1'b1;
                    end
                end
                TLBOP_INV: wb_d.ine = (req_q.inv_op > INV_OP_MAX);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            req_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wb_q    <= wb_d;
        end
    end

    assign wb_op    = wb_q.op;
    assign wb_ine   = wb_q.ine;
    assign wb_index = wb_q.index;
    assign wb_ne    = wb_q.ne;
    assign wb_ps    = wb_q.ps;
    assign wb_vppn  = wb_q.vppn;
    assign wb_asid  = wb_q.asid;
    assign wb_elo0  = wb_q.elo0;
    assign wb_elo1  = wb_q.elo1;

    logic unused_bits;
    assign unused_bits = ^{req_inv_va[11:0], req_q.elo0[31:28], req_q.elo0[7],
                           req_q.elo1[31:28], req_q.elo1[7]};

endmodule

// File: tb/tb_tlb_ctrl.sv
// Scoreboard bench for tlb_ctrl with a behavioural 16-entry TLB attached to its ports.
module tb_tlb_ctrl;
    import tlb_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_inv_op;
    logic [9:0]  req_inv_asid;
    logic [31:0] req_inv_va;
    logic [3:0]  csr_tlbidx_index;
    logic [5:0]  csr_tlbidx_ps;
    logic        csr_tlbidx_ne;
    logic [18:0] csr_tlbehi_vppn;
    logic [31:0] csr_tlbelo0, csr_tlbelo1;
    logic [9:0]  csr_asid;
    logic [5:0]  csr_estat_ecode;
    logic        tlb_s1_sel, tlb_s1_va_bit12;
    logic [18:0] tlb_s1_vppn;
    logic [9:0]  tlb_s1_asid;
    logic        s1_found;
    logic [3:0]  s1_index, tlb_r_index;
    logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;
    logic [18:0] r_vppn;
    logic [5:0]  r_ps;
    logic [9:0]  r_asid;
    logic [19:0] r_ppn0, r_ppn1;
    logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;
    logic        tlb_we, tlb_w_e, tlb_w_g, tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
    logic [3:0]  tlb_w_index;
    logic [18:0] tlb_w_vppn;
    logic [5:0]  tlb_w_ps;
    logic [9:0]  tlb_w_asid;
    logic [19:0] tlb_w_ppn0, tlb_w_ppn1;
    logic [1:0]  tlb_w_plv0, tlb_w_mat0, tlb_w_plv1, tlb_w_mat1;
    logic        tlb_invtlb_valid;
    logic [4:0]  tlb_invtlb_op;
    logic        wb_valid, wb_ine, wb_ne;
    logic [2:0]  wb_op;
    logic [3:0]  wb_index;
    logic [5:0]  wb_ps;
    logic [18:0] wb_vppn;
    logic [9:0]  wb_asid;
    logic [31:0] wb_elo0, wb_elo1;

    tlb_ctrl dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid),
        .req_inv_va(req_inv_va), .csr_tlbidx_index(csr_tlbidx_index),
        .csr_tlbidx_ps(csr_tlbidx_ps), .csr_tlbidx_ne(csr_tlbidx_ne),
        .csr_tlbehi_vppn(csr_tlbehi_vppn), .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1),
        .csr_asid(csr_asid), .csr_estat_ecode(csr_estat_ecode), .tlb_s1_sel(tlb_s1_sel),
        .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_va_bit12(tlb_s1_va_bit12), .tlb_s1_asid(tlb_s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .tlb_r_index(tlb_r_index), .r_e(r_e),
        .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g), .r_ppn0(r_ppn0),
        .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0), .r_ppn1(r_ppn1),
        .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1), .tlb_we(tlb_we),
        .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn),
        .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
        .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0), .tlb_w_mat0(tlb_w_mat0),
        .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0), .tlb_w_ppn1(tlb_w_ppn1),
        .tlb_w_plv1(tlb_w_plv1), .tlb_w_mat1(tlb_w_mat1), .tlb_w_d1(tlb_w_d1),
        .tlb_w_v1(tlb_w_v1), .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_invtlb_op(tlb_invtlb_op),
        .wb_valid(wb_valid), .wb_op(wb_op), .wb_ine(wb_ine), .wb_index(wb_index),
        .wb_ne(wb_ne), .wb_ps(wb_ps), .wb_vppn(wb_vppn), .wb_asid(wb_asid),
        .wb_elo0(wb_elo0), .wb_elo1(wb_elo1)
    );

    // Behavioural TLB array
    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0, mat0;
        logic        d0, v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1, mat1;
        logic        d1, v1;
    } ent_t;

    ent_t tlb_m [16];
    logic tlb_init;

    function automatic ent_t mk_ent(input logic e, input logic [18:0] vppn,
                                    input logic [9:0] asid, input logic g);
        ent_t t = '0;
        t.e = e; t.vppn = vppn; t.asid = asid; t.g = g; t.ps = PS_4K;
        return t;
    endfunction

    function automatic logic vmatch(input ent_t t, input logic [18:0] vppn);
        if (t.ps == PS_4M) return t.vppn[18:9] == vppn[18:9];
        return t.vppn == vppn;
    endfunction

    function automatic logic inv_hit(input ent_t t, input logic [4:0] op,
                                     input logic [9:0] asid, input logic [18:0] vppn);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return t.g;
            5'd3:       return !t.g;
            5'd4:       return !t.g && t.asid == asid;
            5'd5:       return !t.g && t.asid == asid && vmatch(t, vppn);
            5'd6:       return (t.g || t.asid == asid) && vmatch(t, vppn);
            default:    return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (tlb_init) begin
            for (int i = 0; i < 16; i++) tlb_m[i] <= '0;
            tlb_m[1]       <= mk_ent(1'b1, 19'h00000, 10'd0, 1'b0);
            tlb_m[5]       <= mk_ent(1'b1, 19'h12345, 10'd1, 1'b0);
            tlb_m[8]       <= mk_ent(1'b1, 19'h00201, 10'd2, 1'b0);
            tlb_m[9]       <= mk_ent(1'b1, 19'h00201, 10'd2, 1'b1);
            tlb_m[10]      <= mk_ent(1'b1, 19'h00201, 10'd3, 1'b0);
            tlb_m[11]      <= mk_ent(1'b0, 19'h05555, 10'd7, 1'b0);
            tlb_m[11].ppn0 <= 20'hABCDE;
        end else begin
            if (tlb_we)
                tlb_m[tlb_w_index] <= '{e: tlb_w_e, vppn: tlb_w_vppn, ps: tlb_w_ps,
                    asid: tlb_w_asid, g: tlb_w_g, ppn0: tlb_w_ppn0, plv0: tlb_w_plv0,
                    mat0: tlb_w_mat0, d0: tlb_w_d0, v0: tlb_w_v0, ppn1: tlb_w_ppn1,
                    plv1: tlb_w_plv1, mat1: tlb_w_mat1, d1: tlb_w_d1, v1: tlb_w_v1};
            if (tlb_invtlb_valid)
                for (int i = 0; i < 16; i++)
                    if (inv_hit(tlb_m[i], tlb_invtlb_op, tlb_s1_asid, tlb_s1_vppn))
                        tlb_m[i].e <= 1'b0;
        end
    end

    always_comb begin
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = 0; i < 16; i++) begin
            if (tlb_m[i].e && (tlb_m[i].g || tlb_m[i].asid == tlb_s1_asid)
                && vmatch(tlb_m[i], tlb_s1_vppn)) begin
                s1_found = 1'b1;
                s1_index = i[3:0];
            end
        end
    end

    assign r_e    = tlb_m[tlb_r_index].e;
    assign r_vppn = tlb_m[tlb_r_index].vppn;
    assign r_ps   = tlb_m[tlb_r_index].ps;
    assign r_asid = tlb_m[tlb_r_index].asid;
    assign r_g    = tlb_m[tlb_r_index].g;
    assign r_ppn0 = tlb_m[tlb_r_index].ppn0;
    assign r_plv0 = tlb_m[tlb_r_index].plv0;
    assign r_mat0 = tlb_m[tlb_r_index].mat0;
    assign r_d0   = tlb_m[tlb_r_index].d0;
    assign r_v0   = tlb_m[tlb_r_index].v0;
    assign r_ppn1 = tlb_m[tlb_r_index].ppn1;
    assign r_plv1 = tlb_m[tlb_r_index].plv1;
    assign r_mat1 = tlb_m[tlb_r_index].mat1;
    assign r_d1   = tlb_m[tlb_r_index].d1;
    assign r_v1   = tlb_m[tlb_r_index].v1;

    // Reference fill index: counts every clock from reset
    logic [3:0] cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else         cnt <= cnt + 4'd1;
    end

    int inv_cnt = 0;
    always @(posedge clk) if (tlb_invtlb_valid) inv_cnt <= inv_cnt + 1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        ine;
        logic        chk_idx;
        logic [3:0]  index;
        logic        ne;
        logic        chk_rd;
        logic [5:0]  ps;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic [31:0] elo0, elo1;
    } exp_t;

    exp_t sb [$];

    function automatic exp_t mk(input string nm, input logic [2:0] op);
        exp_t e;
        e.name = nm; e.op = op; e.ine = 1'b0; e.chk_idx = 1'b0; e.index = '0; e.ne = 1'b0;
        e.chk_rd = 1'b0; e.ps = '0; e.vppn = '0; e.asid = '0; e.elo0 = '0; e.elo1 = '0;
        return e;
    endfunction

    // Monitor: pops one expectation per result strobe
    always @(negedge clk) begin : mon
        exp_t e;
        if (resetn && wb_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_wb: got wb_valid=1 op=%0d, expected no result", wb_op);
            end else begin
                e = sb.pop_front();
                chk({e.name, ".op"}, 32'(wb_op), 32'(e.op));
                chk({e.name, ".ine"}, 32'(wb_ine), 32'(e.ine));
                if (e.chk_idx) begin
                    chk({e.name, ".index"}, 32'(wb_index), 32'(e.index));
                    chk({e.name, ".ne"}, 32'(wb_ne), 32'(e.ne));
                end
                if (e.chk_rd) begin
                    chk({e.name, ".ne"}, 32'(wb_ne), 32'(e.ne));
                    chk({e.name, ".ps"}, 32'(wb_ps), 32'(e.ps));
                    chk({e.name, ".vppn"}, 32'(wb_vppn), 32'(e.vppn));
                    chk({e.name, ".asid"}, 32'(wb_asid), 32'(e.asid));
                    chk({e.name, ".elo0"}, wb_elo0, e.elo0);
                    chk({e.name, ".elo1"}, wb_elo1, e.elo1);
                end
            end
        end
        if (tlb_we && tlb_invtlb_valid) begin
            n_vec++;
            n_fail++;
            $display("FAIL we_inv_overlap: got both high, expected at most one");
        end
    end

    task automatic set_csr(input logic [3:0] idx, input logic [5:0] ps, input logic ne,
                           input logic [18:0] vppn, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [9:0] asid, input logic [5:0] ecode);
        csr_tlbidx_index = idx; csr_tlbidx_ps = ps; csr_tlbidx_ne = ne;
        csr_tlbehi_vppn = vppn; csr_tlbelo0 = e0; csr_tlbelo1 = e1;
        csr_asid = asid; csr_estat_ecode = ecode;
    endtask

    // Issue one request at a negedge; fill_tgt >= 0 waits for that fill index first
    task automatic send(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] iasid,
                        input logic [31:0] iva, input int fill_tgt);
        int n = 0;
        while (!(req_ready && (fill_tgt < 0 || cnt == fill_tgt[3:0])) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_wait: got ready=%0d cnt=%0d, expected ready and cnt=%0d",
                     req_ready, cnt, fill_tgt);
        end
        req_valid = 1'b1; req_op = op; req_inv_op = iop; req_inv_asid = iasid; req_inv_va = iva;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        // Scramble inputs: the DUT must work from its latched copy
        set_csr(4'($urandom), 6'($urandom), 1'($urandom), 19'($urandom), $urandom, $urandom,
                10'($urandom), 6'($urandom));
        req_inv_op = 5'($urandom); req_inv_asid = 10'($urandom); req_inv_va = $urandom;
        chk("issue.ready", 32'(req_ready), 32'd0);
        chk("issue.wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        chk("resp.wb_valid", 32'(wb_valid), 32'd1);
        chk("resp.ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("done.ready", 32'(req_ready), 32'd1);
        chk("done.wb_valid", 32'(wb_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        resetn = 1'b0; tlb_init = 1'b1; req_valid = 1'b0; req_op = '0;
        req_inv_op = '0; req_inv_asid = '0; req_inv_va = '0;
        set_csr(4'd0, 6'd0, 1'b0, 19'd0, 32'd0, 32'd0, 10'd0, 6'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.tlb_we", 32'(tlb_we), 32'd0);
        chk("rst.invtlb", 32'(tlb_invtlb_valid), 32'd0);
        chk("rst.s1_sel", 32'(tlb_s1_sel), 32'd0);
        chk("rst.wb_index", 32'(wb_index), 32'd0);
        resetn = 1'b1; tlb_init = 1'b0;
        @(negedge clk);

        // SRCH hit then miss
        e = mk("srch_hit", TLBOP_SRCH); e.chk_idx = 1; e.index = 4'd5; e.ne = 0; sb.push_back(e);
        set_csr(4'd7, PS_4K, 1'b0, 19'h12345, 32'd0, 32'd0, 10'd1, 6'd0);
        send(TLBOP_SRCH, 5'd0, 10'd0, 32'd0, -1);
        e = mk("srch_miss", TLBOP_SRCH); e.chk_idx = 1; e.index = 4'd7; e.ne = 1; sb.push_back(e);
        set_csr(4'd7, PS_4K, 1'b0, 19'h7FFFF, 32'd0, 32'd0, 10'd1, 6'd0);
        send(TLBOP_SRCH, 5'd0, 10'd0, 32'd0, -1);

        // WR entry 3, then read it back
        sb.push_back(mk("wr3", TLBOP_WR));
        set_csr(4'd3, PS_4K, 1'b0, 19'h0ABCD, 32'h0001_1153, 32'h0002_220D, 10'd4, 6'd0);
        send(TLBOP_WR, 5'd0, 10'd0, 32'd0, -1);
        chk("wr3.e", 32'(tlb_m[3].e), 32'd1);
        chk("wr3.g", 32'(tlb_m[3].g), 32'd0);
        chk("wr3.vppn", 32'(tlb_m[3].vppn), 32'h0ABCD);
        chk("wr3.ppn0", 32'(tlb_m[3].ppn0), 32'h00111);
        e = mk("rd3", TLBOP_RD); e.chk_rd = 1; e.ne = 0; e.ps = PS_4K; e.vppn = 19'h0ABCD;
        e.asid = 10'd4; e.elo0 = 32'h0001_1113; e.elo1 = 32'h0002_220D; sb.push_back(e);
        set_csr(4'd3, 6'd0, 1'b0, 19'd0, 32'd0, 32'd0, 10'd0, 6'd0);
        send(TLBOP_RD, 5'd0, 10'd0, 32'd0, -1);

        // FILL at fill index 14 (TLBR forces e=1), then at 1 (ne=1 gives e=0)
        sb.push_back(mk("fill14", TLBOP_FILL));
        set_csr(4'd0, PS_4M, 1'b1, 19'h11111, 32'h0003_3341, 32'h0004_4441, 10'd5, 6'h3F);
        send(TLBOP_FILL, 5'd0, 10'd0, 32'd0, 14);
        chk("fill14.e", 32'(tlb_m[14].e), 32'd1);
        chk("fill14.g", 32'(tlb_m[14].g), 32'd1);
        chk("fill14.ps", 32'(tlb_m[14].ps), 32'(PS_4M));
        chk("fill14.vppn", 32'(tlb_m[14].vppn), 32'h11111);
        chk("fill14.ppn0", 32'(tlb_m[14].ppn0), 32'h00333);
        sb.push_back(mk("fill1", TLBOP_FILL));
        set_csr(4'd0, PS_4K, 1'b1, 19'h22222, 32'h0000_0141, 32'h0000_0101, 10'd5, 6'd0);
        send(TLBOP_FILL, 5'd0, 10'd0, 32'd0, 1);
        chk("fill1.e", 32'(tlb_m[1].e), 32'd0);
        chk("fill1.vppn", 32'(tlb_m[1].vppn), 32'h22222);
        chk("fill1.g", 32'(tlb_m[1].g), 32'd0);

        // INVTLB op 5 and an illegal op 7
        sb.push_back(mk("inv5", TLBOP_INV));
        send(TLBOP_INV, 5'd5, 10'd2, 32'h0040_2000, -1);
        chk("inv5.e8", 32'(tlb_m[8].e), 32'd0);
        chk("inv5.e9", 32'(tlb_m[9].e), 32'd1);
        chk("inv5.e10", 32'(tlb_m[10].e), 32'd1);
        chk("inv5.e5", 32'(tlb_m[5].e), 32'd1);
        chk("inv5.pulses", 32'(inv_cnt), 32'd1);
        e = mk("inv7", TLBOP_INV); e.ine = 1; sb.push_back(e);
        send(TLBOP_INV, 5'd7, 10'd2, 32'h0040_2000, -1);
        chk("inv7.pulses", 32'(inv_cnt), 32'd1);
        chk("inv7.e9", 32'(tlb_m[9].e), 32'd1);
        chk("inv7.e10", 32'(tlb_m[10].e), 32'd1);

        // RD of an invalid entry reports zeros
        e = mk("rd11", TLBOP_RD); e.chk_rd = 1; e.ne = 1; sb.push_back(e);
        set_csr(4'd11, PS_4K, 1'b0, 19'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10'd1, 6'd0);
        send(TLBOP_RD, 5'd0, 10'd0, 32'd0, -1);

        // Reset during ISSUE of a WR to entry 12
        set_csr(4'd12, PS_4K, 1'b0, 19'h0F0F0, 32'h0000_0101, 32'h0000_0101, 10'd9, 6'd0);
        req_valid = 1'b1; req_op = TLBOP_WR;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort.we_in_issue", 32'(tlb_we), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("abort.ready", 32'(req_ready), 32'd1);
        chk("abort.wb_valid", 32'(wb_valid), 32'd0);
        chk("abort.tlb_we", 32'(tlb_we), 32'd0);
        chk("abort.wb_op", 32'(wb_op), 32'd0);
        chk("abort.wb_ne", 32'(wb_ne), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        // First FILL after reset must land in entry 0
        sb.push_back(mk("fill0", TLBOP_FILL));
        set_csr(4'd0, PS_4K, 1'b1, 19'h33333, 32'h0000_0101, 32'h0000_0101, 10'd1, 6'h3F);
        send(TLBOP_FILL, 5'd0, 10'd0, 32'd0, -1);
        chk("abort.e12", 32'(tlb_m[12].e), 32'd0);
        chk("abort.vppn12", 32'(tlb_m[12].vppn), 32'd0);
        chk("fill0.e", 32'(tlb_m[0].e), 32'd1);
        chk("fill0.vppn", 32'(tlb_m[0].vppn), 32'h33333);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb_ctrl.md
# tlb_ctrl

Sequencer for the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It sits between the MEM stage and the 16-entry `tlb` array, which it drives through the read port, write port, invtlb port and search port 1. It captures a request, drives the TLB for exactly one cycle, and returns a one-cycle result to the CSR file. Each request takes 3 cycles; requests are not overlapped.

## Interface
- TLBNUM, 16, number of TLB entries; IW = $clog2(TLBNUM).
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous reset, active-low.
- req_valid / req_ready  in / out  1 / 1  request handshake.
- req_op  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV.
- req_inv_op  in  5  INVTLB op field.
- req_inv_asid  in  10  INVTLB rj[9:0].
- req_inv_va  in  32  INVTLB rk.
- csr_tlbidx_index / csr_tlbidx_ps / csr_tlbidx_ne  in  IW / 6 / 1  TLBIDX fields.
- csr_tlbehi_vppn  in  19  TLBEHI VPPN.
- csr_tlbelo0, csr_tlbelo1  in  32 each  TLBELO: V[0], D[1], PLV[3:2], MAT[5:4], G[6], PPN[27:8].
- csr_asid  in  10  ASID.ASID.
- csr_estat_ecode  in  6  ESTAT.Ecode.
- tlb_s1_sel  out  1  when high, MEM muxes the tlb_s1_* signals onto TLB search port 1.
- tlb_s1_vppn / tlb_s1_va_bit12 / tlb_s1_asid  out  19 / 1 / 10  search-port override.
- s1_found / s1_index  in  1 / IW  TLB search result.
- tlb_r_index  out  IW.
- r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0/1, r_plv0/1, r_mat0/1, r_d0/1, r_v0/1  in  TLB read-port widths.
- tlb_we, tlb_w_index, tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g, tlb_w_ppn0/1, tlb_w_plv0/1, tlb_w_mat0/1, tlb_w_d0/1, tlb_w_v0/1  out  TLB write-port widths.
- tlb_invtlb_valid / tlb_invtlb_op  out  1 / 5.
- wb_valid  out  1  one-cycle result strobe.
- wb_op  out  3  op being reported.
- wb_ine  out  1  INVTLB op > 6.
- wb_index / wb_ne / wb_ps  out  IW / 1 / 6  new TLBIDX fields.
- wb_vppn / wb_asid  out  19 / 10  new TLBEHI / ASID fields.
- wb_elo0 / wb_elo1  out  32  new TLBELO values.

## Operation
- State machine: IDLE → ISSUE → RESP → IDLE. req_ready = (state==IDLE).
- On accept (req_valid && req_ready):
  - latch the request fields and all csr_* inputs;
  - for FILL, also latch fill_idx.
- fill_idx: IW-bit counter, increments every cycle, wraps 15→0, reset 0.
- ISSUE drives the TLB from latched values only; every TLB control output is 0 outside ISSUE.
- SRCH:
  - tlb_s1_sel=1, vppn=latched EHI VPPN, asid=latched ASID, va_bit12=0.
  - In RESP: found → wb_index=s1_index, wb_ne=0; not found → wb_index=latched index, wb_ne=1.
- RD:
  - tlb_r_index=latched index.
  - In RESP: r_e=1 → wb_ne=0, and wb_ps/vppn/asid/elo0/elo1 are assembled from r_* with G copied to both ELOs.
  - r_e=0 → wb_ne=1; ps, vppn, asid and both ELOs are 0.
- WR and FILL:
  - tlb_we=1; w_index = latched index (WR) or latched fill_idx (FILL).
  - w_e = 1 if ecode==6'h3F, else ~ne.
  - w_g = elo0.G & elo1.G; w_asid = latched ASID; w_ps = latched ps; remaining fields come from the ELOs.
  - wb carries no CSR update except wb_op.
- INV:
  - op ≤ 6: tlb_invtlb_valid=1 and op passed through; tlb_s1_sel=1, vppn=va[31:13], asid=req_inv_asid.
  - op > 6: nothing is driven to the TLB; wb_ine=1.
- wb_* outputs are registered at the end of ISSUE and valid only while wb_valid=1 (RESP). They hold their value otherwise.
- tlb_we and tlb_invtlb_valid are never high together.

## Timing
- Accept in cycle T. ISSUE in T+1; TLB write/invalidate commits at the T+1→T+2 edge. wb_valid=1 in T+2. req_ready=1 again in T+3.
- A new request can be accepted at the earliest in T+3.
- A request must be held until accepted; req_valid=0 in IDLE means idle.
- Asynchronous reset at any time:
  - state=IDLE, fill_idx=0;
  - all wb_* = 0, all tlb_* outputs = 0, req_ready=1;
  - an in-flight op is abandoned with no wb_valid; a write not yet committed is not performed.
- fill_idx keeps counting during ISSUE and RESP. Its sampled value is frozen at accept.

## Structure
- Package tlb_pkg holds:
  - op codes TLBOP_SRCH/RD/WR/FILL/INV;
  - ECODE_TLBR=6'h3F;
  - ELO bit positions (V, D, PLV, MAT, G, PPN_LSB=8);
  - PS_4K=12, PS_4M=21.
- Sub-module tlb_fill_ctr holds the wrapping free-running index counter.

## Test plan
- SRCH hit: entry 5 has vppn 0x12345, asid 0x01 → wb_valid in T+2, wb_index=5, wb_ne=0. Then a miss → wb_ne=1, wb_index unchanged.
- WR with index=3, ne=0, ecode=0, elo0 G=1, elo1 G=0 → TLB entry 3 has e=1, g=0; a following RD of 3 returns matching wb_elo0/1 with G=0.
- FILL issued twice with fill_idx sampled at accept as 14 then 1 → entries 14 and 1 are written. Also cover ecode=0x3F with ne=1 → w_e=1.
- INV op 5, asid 0x02, va 0x0040_2000 → only the non-global entry with asid 2 and vppn 0x00201 is cleared. INV op 7 → no TLB change, wb_ine=1.
- RD of an entry with e=0 → wb_ne=1, wb_vppn=0, wb_elo0=0, wb_ps=0.
- resetn pulsed low during ISSUE of a WR → no write, no wb_valid, req_ready=1, fill_idx=0.
